// File: rtl/dummy_axis_pkg.sv
// Shared types and constants for the dummy AXI-Stream packet source.
// Holds the FSM state encoding and the LFSR pattern constants.
package dummy_axis_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

endpackage

// File: rtl/dummy_axis_pattern.sv
// Registered data-pattern generator for dummy_axis_src.
// Counter pattern by default; 8-bit LFSR when DUMMY_AXIS_SRC_LFSR_EN is defined.
module dummy_axis_pattern
  import dummy_axis_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] seed,
  input  logic              advance,
  output logic [DATA_W-1:0] value
);

  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] step_val;

  always_comb begin
`ifdef DUMMY_AXIS_SRC_LFSR_EN
    // An all-zero LFSR would lock up, so zero seeds are substituted.
    load_val = (seed == '0) ? LFSR_ZERO_SUB : seed;
    step_val = {value_q[DATA_W-2:0], ^(value_q & LFSR_TAPS)};
`else
    load_val = seed;
    step_val = value_q + DATA_W'(1);
`endif
  end

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (advance) begin
      value_d = step_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/dummy_axis_src.sv
// AXI-Stream master that emits one programmable-length packet per start.
// Data pattern selected by DUMMY_AXIS_SRC_LFSR_EN (see dummy_axis_pattern).
module dummy_axis_src
  import dummy_axis_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_count
);

  state_t state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] beat_nxt;
  logic [15:0]      cnt_q, cnt_d;

  logic tlast_q, tlast_d;
  logic tvalid_q, tvalid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic accept;
  logic load;
  logic advance;

  assign accept   = tvalid_q & m_axis_tready;
  assign last_idx = len_q - LEN_W'(1);
  assign beat_nxt = beat_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    tlast_d = tlast_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && (pkt_len != '0)) begin
          state_d = S_SEND;
          len_d   = pkt_len;
          beat_d  = '0;
          tlast_d = (pkt_len == LEN_W'(1));
          load    = 1'b1;
        end
      end
      S_SEND: begin
        if (accept) begin
          advance = 1'b1;
          if (beat_q == last_idx) begin
            state_d = S_DONE;
            tlast_d = 1'b0;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            beat_d  = beat_nxt;
            tlast_d = (beat_nxt == last_idx);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs are flopped copies of the next-state decode.
    tvalid_d = (state_d == S_SEND);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      beat_q   <= '0;
      cnt_q    <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  dummy_axis_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .seed    (seed),
    .advance (advance),
    .value   (m_axis_tdata)
  );

  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = cnt_q;

endmodule

// File: tb/tb_dummy_axis_src.sv
// Directed self-checking bench for dummy_axis_src.
// Expected beats follow the counter pattern, or the LFSR when DUMMY_AXIS_SRC_LFSR_EN is defined.
module tb_dummy_axis_src;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [7:0]  seed = '0;
  logic        tready = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] q_data[$];
  logic       q_last[$];
  int         q_cyc[$];
  int         stall_err;
  bit         got_done;
  bit         any_busy;

  dummy_axis_src #(
    .DATA_W (8),
    .LEN_W  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pkt_len       (pkt_len),
    .seed          (seed),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (tready),
    .busy          (busy),
    .done          (done),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] exp_beat(input logic [7:0] s, input int idx);
    logic [7:0] v;
`ifdef DUMMY_AXIS_SRC_LFSR_EN
    v = (s == 8'h00) ? 8'h01 : s;
    for (int k = 0; k < idx; k++) v = lfsr_step(v);
`else
    v = s + 8'(idx);
`endif
    return v;
  endfunction

  // Drives tready from a pattern and records every accepted beat until done.
  task automatic collect(input int budget, input logic [31:0] rdy_pat,
                         input int rdy_n, input int pulse_at);
    logic [7:0] pd;
    logic       pl;
    bit         held;
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    stall_err = 0;
    got_done  = 0;
    any_busy  = 0;
    held      = 0;
    pd        = '0;
    pl        = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (i == pulse_at) begin
        pkt_len = 16'd2;
        seed    = 8'h77;
      end
      tready = (i < rdy_n) ? rdy_pat[i] : 1'b1;
      if (held && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl))
        stall_err++;
      if (busy) any_busy = 1;
      if (done) begin
        got_done = 1;
        break;
      end
      if (m_axis_tvalid && tready) begin
        q_data.push_back(m_axis_tdata);
        q_last.push_back(m_axis_tlast);
        q_cyc.push_back(i);
      end
      held = m_axis_tvalid && !tready;
      pd   = m_axis_tdata;
      pl   = m_axis_tlast;
    end
    start  = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fails++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid);
    end
    n_checks++;
    if (m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_data: got %h/%b expected 00/0", m_axis_tdata, m_axis_tlast);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fails++; $display("FAIL reset_status: got busy %b done %b expected 0 0", busy, done);
    end
    n_checks++;
    if (pkt_count !== 16'd0) begin
      n_fails++; $display("FAIL reset_count: got %0d expected 0", pkt_count);
    end
    rst = 1'b0;
    tready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd4; seed = 8'h10;
    collect(30, 32'h0, 0, -1);
    n_checks++;
    if (q_data.size() !== 4) begin
      n_fails++; $display("FAIL basic_nbeats: got %0d expected 4", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 4; k++) begin
      n_checks++;
      if (q_data[k] !== exp_beat(8'h10, k)) begin
        n_fails++;
        $display("FAIL basic_data[%0d]: got %h expected %h", k, q_data[k], exp_beat(8'h10, k));
      end
      n_checks++;
      if (q_last[k] !== (k == 3)) begin
        n_fails++; $display("FAIL basic_tlast[%0d]: got %b expected %b", k, q_last[k], k == 3);
      end
      n_checks++;
      if (q_cyc[k] !== k) begin
        n_fails++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", k, q_cyc[k], k);
      end
    end
    n_checks++;
    if (!got_done || pkt_count !== 16'd1) begin
      n_fails++;
      $display("FAIL basic_done: got done %b count %0d expected 1 1", got_done, pkt_count);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++; $display("FAIL basic_busy_done: got %b expected 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_after: got done %b busy %b tvalid %b expected 0 0 0",
               done, busy, m_axis_tvalid);
    end
  endtask

  task automatic test_backpressure;
    int ec[3] = '{0, 3, 5};
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd3; seed = 8'hFE;
    collect(30, 32'h0000_0029, 6, -1);
    n_checks++;
    if (q_data.size() !== 3) begin
      n_fails++; $display("FAIL bp_nbeats: got %0d expected 3", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 3; k++) begin
      n_checks++;
      if (q_data[k] !== exp_beat(8'hFE, k)) begin
        n_fails++;
        $display("FAIL bp_data[%0d]: got %h expected %h", k, q_data[k], exp_beat(8'hFE, k));
      end
      n_checks++;
      if (q_last[k] !== (k == 2)) begin
        n_fails++; $display("FAIL bp_tlast[%0d]: got %b expected %b", k, q_last[k], k == 2);
      end
      n_checks++;
      if (q_cyc[k] !== ec[k]) begin
        n_fails++; $display("FAIL bp_cycle[%0d]: got %0d expected %0d", k, q_cyc[k], ec[k]);
      end
    end
    n_checks++;
    if (stall_err !== 0) begin
      n_fails++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err);
    end
    n_checks++;
    if (!got_done || pkt_count !== 16'd2) begin
      n_fails++;
      $display("FAIL bp_done: got done %b count %0d expected 1 2", got_done, pkt_count);
    end
    @(negedge clk);
  endtask

  task automatic test_single_zero;
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd1; seed = 8'h5A;
    collect(30, 32'h0, 0, -1);
    n_checks++;
    if (q_data.size() !== 1) begin
      n_fails++; $display("FAIL single_nbeats: got %0d expected 1", q_data.size());
    end else begin
      n_checks++;
      if (q_data[0] !== exp_beat(8'h5A, 0) || q_last[0] !== 1'b1) begin
        n_fails++;
        $display("FAIL single_beat: got %h/%b expected %h/1", q_data[0], q_last[0],
                 exp_beat(8'h5A, 0));
      end
    end
    n_checks++;
    if (!got_done || pkt_count !== 16'd3) begin
      n_fails++;
      $display("FAIL single_done: got done %b count %0d expected 1 3", got_done, pkt_count);
    end
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd0; seed = 8'h33;
    collect(8, 32'h0, 0, -1);
    n_checks++;
    if (q_data.size() !== 0 || any_busy) begin
      n_fails++;
      $display("FAIL zero_len_beats: got %0d beats busy %b expected 0 0", q_data.size(), any_busy);
    end
    n_checks++;
    if (got_done || pkt_count !== 16'd3) begin
      n_fails++;
      $display("FAIL zero_len_done: got done %b count %0d expected 0 3", got_done, pkt_count);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd4; seed = 8'h20;
    collect(30, 32'h0, 0, 1);
    n_checks++;
    if (q_data.size() !== 4) begin
      n_fails++; $display("FAIL ign_nbeats: got %0d expected 4", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 4; k++) begin
      n_checks++;
      if (q_data[k] !== exp_beat(8'h20, k) || q_last[k] !== (k == 3)) begin
        n_fails++;
        $display("FAIL ign_beat[%0d]: got %h/%b expected %h/%b", k, q_data[k], q_last[k],
                 exp_beat(8'h20, k), k == 3);
      end
    end
    n_checks++;
    if (!got_done || pkt_count !== 16'd4) begin
      n_fails++;
      $display("FAIL ign_done: got done %b count %0d expected 1 4", got_done, pkt_count);
    end
    @(negedge clk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_gap: got tvalid %b busy %b expected 0 0", m_axis_tvalid, busy);
    end
    start = 1'b1; pkt_len = 16'd2; seed = 8'h30;
    collect(30, 32'h0, 0, -1);
    n_checks++;
    if (q_data.size() !== 2) begin
      n_fails++; $display("FAIL b2b_nbeats: got %0d expected 2", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 2; k++) begin
      n_checks++;
      if (q_data[k] !== exp_beat(8'h30, k) || q_last[k] !== (k == 1) || q_cyc[k] !== k) begin
        n_fails++;
        $display("FAIL b2b_beat[%0d]: got %h/%b@%0d expected %h/%b@%0d", k, q_data[k],
                 q_last[k], q_cyc[k], exp_beat(8'h30, k), k == 1, k);
      end
    end
    n_checks++;
    if (!got_done || pkt_count !== 16'd5) begin
      n_fails++;
      $display("FAIL b2b_done: got done %b count %0d expected 1 5", got_done, pkt_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd8; seed = 8'h40; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_beat(8'h40, 2)) begin
      n_fails++;
      $display("FAIL rstmid_pre: got tvalid %b data %h expected 1 %h", m_axis_tvalid,
               m_axis_tdata, exp_beat(8'h40, 2));
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL rstmid_abort: got tvalid %b busy %b done %b expected 0 0 0",
               m_axis_tvalid, busy, done);
    end
    n_checks++;
    if (pkt_count !== 16'd0) begin
      n_fails++; $display("FAIL rstmid_count: got %0d expected 0", pkt_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd2; seed = 8'h00;
    collect(30, 32'h0, 0, -1);
    n_checks++;
    if (q_data.size() !== 2) begin
      n_fails++; $display("FAIL rstmid_nbeats: got %0d expected 2", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 2; k++) begin
      n_checks++;
      if (q_data[k] !== exp_beat(8'h00, k) || q_last[k] !== (k == 1)) begin
        n_fails++;
        $display("FAIL rstmid_beat[%0d]: got %h/%b expected %h/%b", k, q_data[k], q_last[k],
                 exp_beat(8'h00, k), k == 1);
      end
    end
    n_checks++;
    if (!got_done || pkt_count !== 16'd1) begin
      n_fails++;
      $display("FAIL rstmid_done: got done %b count %0d expected 1 1", got_done, pkt_count);
    end
    @(negedge clk);
  endtask

`ifdef DUMMY_AXIS_SRC_LFSR_EN
  task automatic test_lfsr;
    logic [7:0] hand[4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd4; seed = 8'h01;
    collect(30, 32'h0, 0, -1);
    n_checks++;
    if (q_data.size() !== 4) begin
      n_fails++; $display("FAIL lfsr_nbeats: got %0d expected 4", q_data.size());
    end
    for (int k = 0; k < q_data.size() && k < 4; k++) begin
      n_checks++;
      if (q_data[k] !== hand[k]) begin
        n_fails++; $display("FAIL lfsr_data[%0d]: got %h expected %h", k, q_data[k], hand[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; pkt_len = 16'd1; seed = 8'h00;
    collect(30, 32'h0, 0, -1);
    n_checks++;
    if (q_data.size() !== 1 || q_data[0] !== 8'h01) begin
      n_fails++;
      $display("FAIL lfsr_zero_seed: got %0d beats first %h expected 1 01", q_data.size(),
               (q_data.size() > 0) ? q_data[0] : 8'hxx);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef DUMMY_AXIS_SRC_LFSR_EN
    test_lfsr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dummy_axis_src.md
Name: dummy_axis_src

Overview:
- AXI-Stream master packet generator; the transmit-side counterpart of the team's dummy AXI-Stream sink.
- Drives the Zynq DMA S2MM slave port (or a sink in loopback) with bursts of known data for DMA bring-up.
- On a start pulse it emits one packet of programmable length, with a deterministic byte pattern, tlast on the final beat, and full tready backpressure handling.

Parameters:
- DATA_W, 8, tdata width in bits; only 8 is supported.
- LEN_W, 16, width of the packet-length input.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle request to send a packet; sampled only in S_IDLE.
- pkt_len  input  LEN_W  packet length in beats; latched on an accepted start.
- seed  input  DATA_W  first data value of the packet; latched on an accepted start.
- m_axis_tdata  output  DATA_W  stream data.
- m_axis_tlast  output  1  high on the final beat of the packet.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready from the slave.
- busy  output  1  high whenever state != S_IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.
- pkt_count  output  16  number of completed packets; wraps at 16 bits.

Behaviour:
- Reset (asynchronous, rst=1): state=S_IDLE; tdata=0, tlast=0, tvalid=0, busy=0, done=0, pkt_count=0; internal beat counter=0.
- States:
  - S_IDLE:
    - start=1 and pkt_len!=0: latch pkt_len and seed, beat counter=0, go to S_SEND.
    - start=1 and pkt_len=0: ignored; stay in S_IDLE, no done pulse.
  - S_SEND: tvalid=1.
    - On accept (tvalid&&tready) of beat index pkt_len-1, go to S_DONE.
    - Otherwise stay in S_SEND.
  - S_DONE: one cycle only; done=1, pkt_count increments by 1, then go to S_IDLE.
- Latency:
  - tvalid rises the cycle after an accepted start.
  - First tdata equals the latched seed.
- Handshake (AXIS master rules):
  - Once tvalid is high it stays high until the beat is accepted.
  - tdata and tlast stay stable while tvalid=1 and tready=0.
  - tvalid never depends combinationally on tready.
- Data pattern (default): tdata = seed + beat index, mod 256; advances only on accept.
- tlast = 1 exactly when beat index == latched pkt_len-1.
  - pkt_len=1: the first beat carries tlast.
- Throughput: with tready held high, one beat per cycle, no bubbles.
- Every output is registered; no combinational path from inputs to outputs.
- start during S_SEND or S_DONE is ignored and not queued.
- A pkt_len or seed change mid-packet has no effect on the packet in flight.
- Back-to-back packets: a start in the S_IDLE cycle following S_DONE is accepted. Minimum gap between packets is 2 cycles with tvalid low (the S_DONE and S_IDLE cycles).
- Reset mid-packet:
  - Abort immediately; tvalid drops asynchronously.
  - No done pulse; pkt_count cleared.
- Beat counter is LEN_W wide; the maximum packet is 2^LEN_W-1 beats.

Optional Feature:
- Macro: DUMMY_AXIS_SRC_LFSR_EN.
- Defined:
  - tdata comes from an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, loaded from seed on accepted start.
  - seed=0 is replaced by 8'h01.
  - The LFSR steps once per accepted beat.
- Not defined: incrementing counter pattern as above. All other behaviour is identical.

Decomposition:
- Package dummy_axis_pkg:
  - state encoding constants S_IDLE, S_SEND, S_DONE;
  - LFSR tap mask 8'hB8;
  - LFSR zero-seed substitute 8'h01.
- Sub-module dummy_axis_pattern:
  - inputs: load, seed, advance;
  - output: registered pattern value;
  - contains the counter/LFSR selection under DUMMY_AXIS_SRC_LFSR_EN.
- The top level holds the FSM, beat counter, tlast and pkt_count.

Test Plan:
- Basic packet: pkt_len=4, seed=8'h10, tready held 1 -> beats 10,11,12,13 on consecutive cycles; tlast only on 13; done pulses once; pkt_count=1.
- Backpressure: pkt_len=3, seed=8'hFE, tready toggled 1,0,0,1,0,1 -> accepted beats FE,FF,00 (wrap); tdata/tlast/tvalid held during stalls; no beat duplicated or dropped.
- Single beat and zero length:
  - pkt_len=1 -> one beat with tlast=1 and done pulse.
  - pkt_len=0 -> tvalid stays 0, no done, pkt_count unchanged.
- Ignored start and back-to-back: start re-pulsed mid-packet is ignored; start in the first S_IDLE cycle after S_DONE -> second packet; pkt_count=2.
- Reset mid-packet: rst asserted after beat 2 of 8 -> tvalid=0 immediately; pkt_count=0; next start (pkt_len=2, seed=8'h00) -> 00,01 with tlast on 01.
- LFSR build: seed=8'h01, pkt_len=4, DUMMY_AXIS_SRC_LFSR_EN defined -> tdata sequence matches the bench reference LFSR model. seed=0 -> first beat 8'h01.
